ram_loader_ctrl: RTL and testbench

Sequencer that fills the CPU's 16-byte program RAM from the pins before execution starts. It owns the 8-bit bus and the MAR/RAM load strobes while programming mode is requested, and holds the CPU core (control block, program counter) stopped. When programming ends it releases the bus and asserts `cpu_run`. It sits beside the control block in the top level; its strobes are ANDed (active-low) with the control block's `nLma`/`nLmd`/write strobes.

---
 rtl/ram_loader_pkg.sv | 21 ++
 rtl/ram_loader_ctrl_sync_rise_detect.sv | 31 +++
 rtl/ram_loader_ctrl.sv | 135 +++++++++++++
 tb/tb_ram_loader_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the program-RAM loader: FSM states, default sizing
// and the idle level of the active-low load/write strobes.
package ram_loader_pkg;

    localparam int RAM_BYTES_DEF = 16;
    localparam int ADDR_W_DEF    = 4;

    // {n_load_addr, n_load_data, ram_we_n} when nothing is being loaded
    localparam logic [2:0] STROBES_INACTIVE = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT_BYTE,
        LOAD_ADDR,
        LOAD_DATA,
        WRITE,
        FULL
    } state_t;

endpackage

// File: rtl/ram_loader_ctrl_sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous pin strobe, followed by a
// registered rising-edge detector that emits a one-cycle pulse.
module sync_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_syncPrev;
    logic r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_syncPrev <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_sync1    <= i_async;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
            r_pulse    <= r_sync2 & ~r_syncPrev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/ram_loader_ctrl.sv
// Loads the CPU program RAM from the pins while prog_en is held, keeping the
// core stopped and owning the bus; releases the bus and runs the CPU afterwards.
module ram_loader_ctrl
    import ram_loader_pkg::*;
#(
    parameter int RAM_BYTES = RAM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_en,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              n_load_addr,
    output logic              n_load_data,
    output logic              ram_we_n,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              done
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(RAM_BYTES);

    state_t              r_state;
    state_t              w_stateNext;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic                r_done;
    logic [7:0]          r_hold;
    logic                w_bytePulse;
    logic [ADDR_W:0]     w_countInc;

    sync_rise_detect u_validSync (
        .clk     (clk),
        .rst     (rst),
        .i_async (byte_valid),
        .o_pulse (w_bytePulse)
    );

    assign w_countInc = r_count + (ADDR_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A started write always runs to completion; prog_en is only honoured
    // once the WRITE cycle has been issued.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:      w_stateNext = prog_en ? WAIT_BYTE : RUN;
            RUN:       if (prog_en) w_stateNext = WAIT_BYTE;
            WAIT_BYTE: begin
                if (!prog_en) begin
                    w_stateNext = RUN;
                end else if (w_bytePulse) begin
                    w_stateNext = LOAD_ADDR;
                end
            end
            LOAD_ADDR: w_stateNext = LOAD_DATA;
            LOAD_DATA: w_stateNext = WRITE;
            WRITE: begin
                if (w_countInc == FULL_COUNT) begin
                    w_stateNext = FULL;
                end else if (!prog_en) begin
                    w_stateNext = RUN;
                end else begin
                    w_stateNext = WAIT_BYTE;
                end
            end
            FULL:      if (!prog_en) w_stateNext = RUN;
            default:   w_stateNext = IDLE;
        endcase
    end

    // Address saturates on the final write so it never wraps back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_hold  <= 8'h00;
        end else begin
            if ((r_state == RUN || r_state == IDLE) && w_stateNext == WAIT_BYTE) begin
                r_addr  <= '0;
                r_count <= '0;
                r_done  <= 1'b0;
            end
            if (r_state == WAIT_BYTE && w_stateNext == LOAD_ADDR) begin
                r_hold <= byte_in;
            end
            if (r_state == WRITE) begin
                r_count <= w_countInc;
                if (w_countInc == FULL_COUNT) begin
                    r_done <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        cpu_run    = (r_state == RUN);
        byte_ready = (r_state == WAIT_BYTE);
        bus_oe     = 1'b0;
        bus_out    = 8'h00;
        {n_load_addr, n_load_data, ram_we_n} = STROBES_INACTIVE;
        case (r_state)
            LOAD_ADDR: begin
                bus_oe      = 1'b1;
                bus_out     = 8'(r_addr);
                n_load_addr = 1'b0;
            end
            LOAD_DATA: begin
                bus_oe      = 1'b1;
                bus_out     = r_hold;
                n_load_data = 1'b0;
            end
            WRITE:     ram_we_n = 1'b0;
            default:   ;
        endcase
    end

    assign load_count = r_count;
    assign done       = r_done;

endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Directed self-checking bench for ram_loader_ctrl: reset, byte loading,
// full-RAM saturation, abort, re-entry and reset during a write.
module tb_ram_loader_ctrl;

    logic       clk;
    logic       rst;
    logic       prog_en;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       n_load_addr;
    logic       n_load_data;
    logic       ram_we_n;
    logic       cpu_run;
    logic [4:0] load_count;
    logic       done;

    int errors = 0;
    int checks = 0;

    ram_loader_ctrl #(.RAM_BYTES(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_en     (prog_en),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .n_load_addr (n_load_addr),
        .n_load_data (n_load_data),
        .ram_we_n    (ram_we_n),
        .cpu_run     (cpu_run),
        .load_count  (load_count),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one byte and follows it through LOAD_ADDR, LOAD_DATA, WRITE.
    // mode 0: normal, 1: drop prog_en during LOAD_DATA, 2: assert rst during WRITE.
    // Returns at the negedge of the WRITE cycle.
    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] expAddr, input int mode);
        int  lat;
        bit  found;
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_before_byte: byte_ready=%b expected 1", byte_ready);
        end
        byte_in    = data;
        byte_valid = 1'b1;
        lat   = 0;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (n_load_addr === 1'b0) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL load_addr_timeout: no n_load_addr within 8 cycles (byte %h)", data);
            byte_valid = 1'b0;
            return;
        end
        if (lat < 3 || lat > 4) begin
            errors++;
            $display("[TB] FAIL edge_latency: got %0d cycles, expected 3..4", lat);
        end
        checks++;
        if (bus_oe !== 1'b1 || bus_out !== {4'h0, expAddr}) begin
            errors++;
            $display("[TB] FAIL load_addr_bus: oe=%b bus=%h expected oe=1 bus=%h", bus_oe, bus_out, {4'h0, expAddr});
        end
        @(negedge clk);
        checks++;
        if (n_load_data !== 1'b0 || n_load_addr !== 1'b1 || bus_oe !== 1'b1 || bus_out !== data) begin
            errors++;
            $display("[TB] FAIL load_data: nla=%b nld=%b oe=%b bus=%h expected 1/0/1/%h",
                     n_load_addr, n_load_data, bus_oe, bus_out, data);
        end
        if (mode == 1) prog_en = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_we_n !== 1'b0 || n_load_data !== 1'b1 || bus_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_cycle: we_n=%b nld=%b oe=%b expected 0/1/0", ram_we_n, n_load_data, bus_oe);
        end
        byte_valid = 1'b0;
        if (mode == 2) rst = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        prog_en    = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_run !== 1'b0 || bus_oe !== 1'b0 || bus_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_bus: run=%b oe=%b bus=%h expected 0/0/00", cpu_run, bus_oe, bus_out);
        end
        checks++;
        if ({n_load_addr, n_load_data, ram_we_n} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected 111", {n_load_addr, n_load_data, ram_we_n});
        end
        checks++;
        if (byte_ready !== 1'b0 || load_count !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: ready=%b count=%0d done=%b expected 0/0/0", byte_ready, load_count, done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_run !== 1'b1 || bus_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_to_run: run=%b oe=%b expected 1/0", cpu_run, bus_oe);
        end
    endtask

    task automatic test_three_bytes();
        logic [7:0] bytes [3];
        bytes[0] = 8'h1E;
        bytes[1] = 8'h2F;
        bytes[2] = 8'hE0;
        prog_en = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_run !== 1'b0 || byte_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL enter_prog: run=%b ready=%b expected 0/1", cpu_run, byte_ready);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(bytes[i], 4'(i), 0);
            @(negedge clk);
            checks++;
            if (byte_ready !== 1'b1 || load_count !== 5'(i + 1)) begin
                errors++;
                $display("[TB] FAIL three_bytes_count: ready=%b count=%0d expected 1/%0d", byte_ready, load_count, i + 1);
            end
        end
    endtask

    task automatic test_full_load();
        bit sawActivity;
        prog_en = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_run !== 1'b1 || bus_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL leave_prog: run=%b oe=%b expected 1/0", cpu_run, bus_oe);
        end
        prog_en = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_run !== 1'b0 || load_count !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reenter_clear: run=%b count=%0d done=%b expected 0/0/0", cpu_run, load_count, done);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), 4'(i), 0);
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || load_count !== 5'd16 || byte_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_state: done=%b count=%0d ready=%b expected 1/16/0", done, load_count, byte_ready);
        end
        // A 17th strobe in FULL must be ignored entirely
        byte_in     = 8'hAA;
        byte_valid  = 1'b1;
        sawActivity = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ({n_load_addr, n_load_data, ram_we_n} !== 3'b111 || bus_oe !== 1'b0) sawActivity = 1;
        end
        byte_valid = 1'b0;
        checks++;
        if (sawActivity || load_count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL extra_strobe: activity=%b count=%0d expected 0/16", sawActivity, load_count);
        end
    endtask

    task automatic test_reenter();
        prog_en = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_run !== 1'b1 || done !== 1'b1 || load_count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL run_after_full: run=%b done=%b count=%0d expected 1/1/16", cpu_run, done, load_count);
        end
        prog_en = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_run !== 1'b0 || done !== 1'b0 || load_count !== 5'd0 || byte_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reenter_after_full: run=%b done=%b count=%0d ready=%b expected 0/0/0/1",
                     cpu_run, done, load_count, byte_ready);
        end
        applyStimulus(8'hA5, 4'h0, 0);
        @(negedge clk);
        checks++;
        if (load_count !== 5'd1) begin
            errors++;
            $display("[TB] FAIL reenter_first_write: count=%0d expected 1", load_count);
        end
    endtask

    task automatic test_abort();
        applyStimulus(8'h11, 4'h1, 0);
        @(negedge clk);
        applyStimulus(8'h22, 4'h2, 0);
        @(negedge clk);
        applyStimulus(8'h33, 4'h3, 0);
        @(negedge clk);
        applyStimulus(8'h44, 4'h4, 1);
        @(negedge clk);
        checks++;
        if (cpu_run !== 1'b1 || bus_oe !== 1'b0 || load_count !== 5'd5 || byte_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_to_run: run=%b oe=%b count=%0d ready=%b expected 1/0/5/0",
                     cpu_run, bus_oe, load_count, byte_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        prog_en = 1'b1;
        @(negedge clk);
        applyStimulus(8'h5A, 4'h0, 2);
        @(negedge clk);
        checks++;
        if ({n_load_addr, n_load_data, ram_we_n} !== 3'b111 || bus_oe !== 1'b0 ||
            cpu_run !== 1'b0 || load_count !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_write: strobes=%b oe=%b run=%b count=%0d expected 111/0/0/0",
                     {n_load_addr, n_load_data, ram_we_n}, bus_oe, cpu_run, load_count);
        end
        rst     = 1'b0;
        prog_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_three_bytes();
        test_full_load();
        test_reenter();
        test_abort();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
